// File: rtl/ti_share_skid_stage_if.sv
// Handshake and share bus for ti_share_skid_stage.
// The slave modport is the stage's own view; master is the driving and sampling side.
interface ti_share_skid_stage_if #(
  parameter int SHARE_W = 4,
  parameter int NIBBLES = 16
);
  localparam int POS_W = $clog2(NIBBLES);

  logic               in_valid;
  logic               in_ready;
  logic [SHARE_W-1:0] x1;
  logic [SHARE_W-1:0] x2;
  logic [SHARE_W-1:0] x3;
  logic [2*SHARE_W-1:0] rnd;
  logic               out_valid;
  logic               out_ready;
  logic [SHARE_W-1:0] y1;
  logic [SHARE_W-1:0] y2;
  logic [SHARE_W-1:0] y3;
  logic               out_last;
  logic [POS_W-1:0]   pos;

  modport slave (
    input  in_valid, x1, x2, x3, rnd, out_ready,
    output in_ready, out_valid, y1, y2, y3, out_last, pos
  );

  modport master (
    output in_valid, x1, x2, x3, rnd, out_ready,
    input  in_ready, out_valid, y1, y2, y3, out_last, pos
  );
endinterface

// File: rtl/ti_share_skid_stage.sv
// Registered 3-share skid stage between the PRINCE TI S-box and the affine layer.
// Define REMASK_EN to refresh the shares with rnd as each triple is stored.
module ti_share_skid_stage #(
  parameter int SHARE_W = 4,
  parameter int NIBBLES = 16
) (
  input logic clk,
  input logic rst,
  ti_share_skid_stage_if.slave bus
);
  localparam int POS_W = $clog2(NIBBLES);

  logic [SHARE_W-1:0] main1_q, main2_q, main3_q;
  logic [SHARE_W-1:0] main1_d, main2_d, main3_d;
  logic [SHARE_W-1:0] skid1_q, skid2_q, skid3_q;
  logic [SHARE_W-1:0] skid1_d, skid2_d, skid3_d;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               in_ready_q;
  logic [POS_W-1:0]   cnt_q, cnt_d;

  logic [SHARE_W-1:0] st1, st2, st3;
  logic               accept, emit;

  // Each share is masked on its own path; no share ever meets another share.
`ifdef REMASK_EN
  logic [SHARE_W-1:0] r1, r2;
  assign r1  = bus.rnd[SHARE_W-1:0];
  assign r2  = bus.rnd[2*SHARE_W-1:SHARE_W];
  assign st1 = bus.x1 ^ r1;
  assign st2 = bus.x2 ^ r2;
  assign st3 = bus.x3 ^ r1 ^ r2;
`else
  assign st1 = bus.x1;
  assign st2 = bus.x2;
  assign st3 = bus.x3;
`endif

  assign accept = bus.in_valid && in_ready_q;
  assign emit   = main_valid_q && bus.out_ready;

  always_comb begin
    main1_d      = main1_q;
    main2_d      = main2_q;
    main3_d      = main3_q;
    skid1_d      = skid1_q;
    skid2_d      = skid2_q;
    skid3_d      = skid3_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (emit) begin
      cnt_d = cnt_q + 1'b1;
      if (skid_valid_q) begin
        main1_d      = skid1_q;
        main2_d      = skid2_q;
        main3_d      = skid3_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main1_d = st1;
        main2_d = st2;
        main3_d = st3;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main1_d      = st1;
        main2_d      = st2;
        main3_d      = st3;
        main_valid_d = 1'b1;
      end else begin
        skid1_d      = st1;
        skid2_d      = st2;
        skid3_d      = st3;
        skid_valid_d = 1'b1;
      end
    end
  end

  // in_ready is registered from the next skid state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main1_q      <= '0;
      main2_q      <= '0;
      main3_q      <= '0;
      skid1_q      <= '0;
      skid2_q      <= '0;
      skid3_q      <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main1_q      <= main1_d;
      main2_q      <= main2_d;
      main3_q      <= main3_d;
      skid1_q      <= skid1_d;
      skid2_q      <= skid2_d;
      skid3_q      <= skid3_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.y1        = main1_q;
  assign bus.y2        = main2_q;
  assign bus.y3        = main3_q;
  assign bus.pos       = cnt_q;
  assign bus.out_last  = main_valid_q && (cnt_q == POS_W'(NIBBLES - 1));
endmodule

// File: tb/tb_ti_share_skid_stage.sv
// Directed self-checking bench for ti_share_skid_stage; inputs change and outputs are sampled on the falling edge.
module tb_ti_share_skid_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ti_share_skid_stage_if #(.SHARE_W(4), .NIBBLES(16)) bus ();

  ti_share_skid_stage #(.SHARE_W(4), .NIBBLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1 = 4'h0; bus.x2 = 4'h0; bus.x3 = 4'h0; bus.rnd = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1 = 4'hF; bus.x2 = 4'hF; bus.x3 = 4'hF; bus.rnd = 8'h00;
    repeat (3) @(negedge clk);
    got = {bus.y1, bus.y2, bus.y3, bus.out_valid, bus.out_last, bus.in_ready, 1'b0};
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0000", got);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.pos} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL idle_after_reset: got rdy=%b vld=%b pos=%h expected 1 0 0",
                         bus.in_ready, bus.out_valid, bus.pos);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'hA; bus.x2 = 4'h3; bus.x3 = 4'h5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos} !== {1'b1, 12'hA35, 4'h0}) begin
      n_fail++; $display("FAIL single_out: got vld=%b y=%h%h%h pos=%h expected 1 a35 0",
                         bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos);
    end
    n_checks++;
    if ((bus.y1 ^ bus.y2 ^ bus.y3) !== 4'hC) begin
      n_fail++; $display("FAIL single_xor: got %h expected c", bus.y1 ^ bus.y2 ^ bus.y3);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.pos, bus.in_ready} !== {1'b0, 4'h1, 1'b1}) begin
      n_fail++; $display("FAIL single_drain: got vld=%b pos=%h rdy=%b expected 0 1 1",
                         bus.out_valid, bus.pos, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'h1; bus.x2 = 4'h2; bus.x3 = 4'h3;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3} !== {2'b11, 12'h123}) begin
      n_fail++; $display("FAIL bp_t0_loaded: got rdy=%b vld=%b y=%h%h%h expected 1 1 123",
                         bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3);
    end
    bus.x1 = 4'h4; bus.x2 = 4'h5; bus.x3 = 4'h6;
    @(negedge clk);
    bus.x1 = 4'h7; bus.x2 = 4'h7; bus.x3 = 4'h7;
    n_checks++;
    if ({bus.in_ready, bus.y1, bus.y2, bus.y3} !== {1'b0, 12'h123}) begin
      n_fail++; $display("FAIL bp_skid_full: got rdy=%b y=%h%h%h expected 0 123",
                         bus.in_ready, bus.y1, bus.y2, bus.y3);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos} !== {2'b01, 12'h123, 4'h0}) begin
      n_fail++; $display("FAIL bp_stall_hold: got rdy=%b vld=%b y=%h%h%h pos=%h expected 0 1 123 0",
                         bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos} !== {2'b11, 12'h456, 4'h1}) begin
      n_fail++; $display("FAIL bp_t1_emit: got rdy=%b vld=%b y=%h%h%h pos=%h expected 1 1 456 1",
                         bus.in_ready, bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.pos} !== {2'b10, 4'h2}) begin
      n_fail++; $display("FAIL bp_drained: got rdy=%b vld=%b pos=%h expected 1 0 2",
                         bus.in_ready, bus.out_valid, bus.pos);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] i4;
    logic [3:0] e_pos;
    logic       e_last;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'h0; bus.x2 = 4'hF; bus.x3 = 4'h3;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      i4     = 4'(i);
      e_pos  = 4'(i % 16);
      e_last = (i == 15);
      n_checks++;
      if ({bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos, bus.out_last} !==
          {1'b1, i4, ~i4, i4 + 4'h3, e_pos, e_last}) begin
        n_fail++; $display("FAIL wrap_%0d: got vld=%b y=%h%h%h pos=%h last=%b expected 1 %h%h%h %h %b",
                           i, bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos, bus.out_last,
                           i4, ~i4, i4 + 4'h3, e_pos, e_last);
      end
      i4 = 4'(i + 1);
      bus.x1 = i4; bus.x2 = ~i4; bus.x3 = i4 + 4'h3;
      if (i == 16) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'h1; bus.x2 = 4'h1; bus.x3 = 4'h1;
    @(negedge clk);
    bus.x1 = 4'h2; bus.x2 = 4'h2; bus.x3 = 4'h2;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.x1 = 4'h3; bus.x2 = 4'h3; bus.x3 = 4'h3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.y1, bus.pos} !== {2'b01, 4'h2, 4'h1}) begin
      n_fail++; $display("FAIL mid_before_rst: got rdy=%b vld=%b y1=%h pos=%h expected 0 1 2 1",
                         bus.in_ready, bus.out_valid, bus.y1, bus.pos);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.pos, bus.y1, bus.out_last, bus.in_ready} !== {1'b0, 4'h0, 4'h0, 2'b00}) begin
      n_fail++; $display("FAIL mid_async_rst: got vld=%b pos=%h y1=%h last=%b rdy=%b expected 0 0 0 0 0",
                         bus.out_valid, bus.pos, bus.y1, bus.out_last, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'h9; bus.x2 = 4'h8; bus.x3 = 4'h7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos} !== {1'b1, 12'h987, 4'h0}) begin
      n_fail++; $display("FAIL mid_after_rst: got vld=%b y=%h%h%h pos=%h expected 1 987 0",
                         bus.out_valid, bus.y1, bus.y2, bus.y3, bus.pos);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.pos} !== {1'b0, 4'h1}) begin
      n_fail++; $display("FAIL mid_no_stale: got vld=%b pos=%h expected 0 1", bus.out_valid, bus.pos);
    end
  endtask

  task automatic test_remask();
    logic [11:0] exp_y;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x1 = 4'h1; bus.x2 = 4'h2; bus.x3 = 4'h4; bus.rnd = 8'h96;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rnd      = 8'hFF;
`ifdef REMASK_EN
    exp_y = 12'h7BB;
`else
    exp_y = 12'h124;
`endif
    n_checks++;
    if ({bus.y1, bus.y2, bus.y3} !== exp_y) begin
      n_fail++; $display("FAIL remask_shares: got %h%h%h expected %h", bus.y1, bus.y2, bus.y3, exp_y);
    end
    n_checks++;
    if ((bus.y1 ^ bus.y2 ^ bus.y3) !== 4'h7) begin
      n_fail++; $display("FAIL remask_xor: got %h expected 7", bus.y1 ^ bus.y2 ^ bus.y3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_remask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
